// File: rtl/sd_cmd_xcvr.sv
// SD CMD line transceiver: sends a 48-bit command frame with CRC7, waits for the
// response start bit and delivers 48- or 136-bit responses as numbered bytes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; sdclken ignored
// TX    | shifting out start, dir, index, argument, CRC7, end bit
// NCR   | line released, counting down strobes until a response start bit
// RX    | shifting response bits into CMDSI, checking CRC7
// FIN   | one-cycle completion, tcvcptdone asserted on exit
module sd_cmd_xcvr #(
    parameter int         NCR_MAX  = 64,
    parameter logic [6:0] CRC_POLY = 7'h09
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  CMDIDX,
    input  logic [31:0] CMDARG,
    input  logic [1:0]  rsptype,
    input  logic        crcchk,
    input  logic        sdclken,
    input  logic        cmdin,
    output logic        cmdout,
    output logic        cmdoe,
    output logic        busy,
    output logic [7:0]  CMDSI,
    output logic [4:0]  PTCMDPNTR,
    output logic        sbdone,
    output logic        tcvcptdone,
    output logic        rsptout,
    output logic        crcerr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TX   = 3'd1;
    localparam logic [2:0] S_NCR  = 3'd2;
    localparam logic [2:0] S_RX   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int NCR_W = $clog2(NCR_MAX + 1);

    logic [2:0]       state;
    logic [1:0]       rtype;
    logic             chk;
    logic [39:0]      tx_sr;
    logic [6:0]       crc;
    logic [7:0]       bit_cnt;
    logic [NCR_W-1:0] ncr_cnt;

    logic long_rsp, rx_strobe, in_crc, in_cmp, last_bit;

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
    endfunction

    assign busy     = (state != S_IDLE);
    assign long_rsp = (rtype == 2'd2);
    // The start bit seen in NCR is processed as response bit 0.
    assign rx_strobe = sdclken && ((state == S_RX) || ((state == S_NCR) && !cmdin));

    always_comb begin
        in_crc   = 1'b0;
        in_cmp   = 1'b0;
        last_bit = 1'b0;
        if (long_rsp) begin
            in_crc   = (bit_cnt >= 8'd8) && (bit_cnt <= 8'd127);
            in_cmp   = (bit_cnt >= 8'd128) && (bit_cnt <= 8'd134);
            last_bit = (bit_cnt == 8'd135);
        end else begin
            in_crc   = (bit_cnt <= 8'd39);
            in_cmp   = (bit_cnt >= 8'd40) && (bit_cnt <= 8'd46);
            last_bit = (bit_cnt == 8'd47);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmdout     <= 1'b1;
            cmdoe      <= 1'b0;
            CMDSI      <= 8'h00;
            PTCMDPNTR  <= 5'd0;
            sbdone     <= 1'b0;
            tcvcptdone <= 1'b0;
            rsptout    <= 1'b0;
            crcerr     <= 1'b0;
            rtype      <= 2'd0;
            chk        <= 1'b0;
            tx_sr      <= 40'd0;
            crc        <= 7'd0;
            bit_cnt    <= 8'd0;
            ncr_cnt    <= '0;
        end else begin
            sbdone     <= 1'b0;
            tcvcptdone <= 1'b0;

            if (rx_strobe) begin
                CMDSI <= {CMDSI[6:0], cmdin};
                if (in_crc) begin
                    crc <= crc_step(crc, cmdin);
                end else if (in_cmp) begin
                    crc <= {crc[5:0], 1'b0};
                    if (chk && (cmdin != crc[6])) crcerr <= 1'b1;
                end
                if (bit_cnt[2:0] == 3'd7) begin
                    sbdone <= 1'b1;
                    if (PTCMDPNTR != 5'd17) PTCMDPNTR <= PTCMDPNTR + 5'd1;
                end
                if (last_bit) begin
                    state <= S_FIN;
                end else begin
                    state   <= S_RX;
                    bit_cnt <= bit_cnt + 8'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rtype     <= rsptype;
                        chk       <= crcchk;
                        tx_sr     <= {2'b01, CMDIDX, CMDARG};
                        crc       <= 7'd0;
                        bit_cnt   <= 8'd0;
                        PTCMDPNTR <= 5'd0;
                        rsptout   <= 1'b0;
                        crcerr    <= 1'b0;
                        state     <= S_TX;
                    end
                end
                S_TX: begin
                    if (sdclken) begin
                        cmdoe   <= 1'b1;
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_cnt < 8'd40) begin
                            cmdout <= tx_sr[39];
                            tx_sr  <= {tx_sr[38:0], 1'b0};
                            crc    <= crc_step(crc, tx_sr[39]);
                        end else if (bit_cnt < 8'd47) begin
                            cmdout <= crc[6];
                            crc    <= {crc[5:0], 1'b0};
                        end else if (bit_cnt == 8'd47) begin
                            cmdout <= 1'b1;
                        end else begin
                            // Strobe after the end bit: release the line.
                            cmdout  <= 1'b1;
                            cmdoe   <= 1'b0;
                            bit_cnt <= 8'd0;
                            crc     <= 7'd0;
                            ncr_cnt <= NCR_W'(NCR_MAX);
                            state   <= (rtype == 2'd0) ? S_FIN : S_NCR;
                        end
                    end
                end
                S_NCR: begin
                    if (sdclken && cmdin) begin
                        if (ncr_cnt == NCR_W'(1)) begin
                            rsptout <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            ncr_cnt <= ncr_cnt - NCR_W'(1);
                        end
                    end
                end
                S_RX: ;
                S_FIN: begin
                    tcvcptdone <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
